// File: rtl/mac_saturado_filtro.sv
// Pipelined signed fixed-point multiply-accumulate with symmetric output saturation.
// Optional build macro REDONDEO_EN: round half up before the final rescale instead of truncating.
module mac_saturado_filtro #(
  parameter int Width     = 22,
  parameter int Presicion = 14,
  parameter int AccGuard  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [Width-1:0] A,
  input  logic signed [Width-1:0] B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [Width-1:0] Y,
  output logic                    sat_flag
);

  localparam int PW = 2 * Width;
  localparam int AW = PW + AccGuard;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [AW:0]   Y_MAX   = {{(AW+2-Width){1'b0}}, {(Width-1){1'b1}}};
  localparam logic signed [AW:0]   Y_MIN   = {{(AW+2-Width){1'b1}}, {(Width-2){1'b0}}, 1'b1};
`ifdef REDONDEO_EN
  localparam logic signed [AW:0]   RND     = {{(AW+1-Presicion){1'b0}}, 1'b1, {(Presicion-1){1'b0}}};
`endif

  logic w_advance;

  logic signed [PW-1:0] w_a_ext, w_b_ext, w_prod;
  logic signed [PW-1:0] r_prod;
  logic                 r_s1_valid, r_s1_first, r_s1_last;

  logic signed [AW-1:0] w_prod_ext, w_base, w_sum;
  logic signed [AW:0]   w_sum_wide;
  logic signed [AW-1:0] r_acc, r_s2_sum;
  logic                 r_s2_valid;

  logic signed [AW:0]      w_pre, w_shift;
  logic signed [Width-1:0] w_y;
  logic                    w_sat;

  // The whole pipeline moves in lock-step; a stalled output freezes every stage.
  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  // S1: full-precision product
  assign w_a_ext = {{Width{A[Width-1]}}, A};
  assign w_b_ext = {{Width{B[Width-1]}}, B};
  assign w_prod  = w_a_ext * w_b_ext;

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_prod     <= w_prod;
        r_s1_first <= in_first;
        r_s1_last  <= in_last;
      end
    end
  end

  // S2: accumulate with clamping at the accumulator's own bounds
  assign w_prod_ext = {{AccGuard{r_prod[PW-1]}}, r_prod};
  assign w_base     = r_s1_first ? '0 : r_acc;
  assign w_sum_wide = {w_base[AW-1], w_base} + {w_prod_ext[AW-1], w_prod_ext};

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_sum = w_sum_wide[AW-1:0];
    if (w_sum_wide[AW] != w_sum_wide[AW-1])
      w_sum = w_sum_wide[AW] ? ACC_MIN : ACC_MAX;
  end

  // The completed frame sum moves to r_s2_sum while r_acc restarts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_s2_sum   <= '0;
      r_s2_valid <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        if (r_s1_last) begin
          r_s2_sum <= w_sum;
          r_acc    <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  // S3: rescale (floor or round half up) then clip to the symmetric range
`ifdef REDONDEO_EN
  assign w_pre = {r_s2_sum[AW-1], r_s2_sum} + RND;
`else
  assign w_pre = {r_s2_sum[AW-1], r_s2_sum};
`endif
  assign w_shift = w_pre >>> Presicion;

  always_comb begin
    w_y   = w_shift[Width-1:0];
    w_sat = 1'b0;
    if (w_shift > Y_MAX) begin
      w_y   = Y_MAX[Width-1:0];
      w_sat = 1'b1;
    end else if (w_shift < Y_MIN) begin
      w_y   = Y_MIN[Width-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      Y         <= '0;
      sat_flag  <= 1'b0;
    end else if (w_advance) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        Y        <= w_y;
        sat_flag <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_mac_saturado_filtro.sv
// Self-checking bench for mac_saturado_filtro: vector table, corner sequences, scoreboard queue.
module tb_mac_saturado_filtro;

  localparam int W = 22;
  localparam int P = 14;
  localparam longint YMAX = (64'sd1 <<< (W-1)) - 1;

  logic                clk, reset;
  logic                in_valid, in_ready, in_first, in_last;
  logic signed [W-1:0] A, B, Y;
  logic                out_valid, out_ready, sat_flag;

  mac_saturado_filtro dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [W-1:0] y;
    logic                sat;
  } exp_t;

  typedef struct {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] y;
    logic                sat;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   bp_en    = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: one transfer per cycle with out_valid & out_ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got Y=%0d with no result pending", Y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("Y", longint'(Y), longint'(e.y));
        check("sat_flag", longint'(sat_flag), longint'(e.sat));
      end
    end
  end

  function automatic exp_t model(input longint sum);
    longint r;
    exp_t   e;
`ifdef REDONDEO_EN
    r = (sum + (64'sd1 <<< (P-1))) >>> P;
`else
    r = sum >>> P;
`endif
    e.sat = 1'b0;
    if (r > YMAX) begin
      r = YMAX; e.sat = 1'b1;
    end else if (r < -YMAX) begin
      r = -YMAX; e.sat = 1'b1;
    end
    e.y = W'(r);
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_beat(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                           input logic first, input logic last,
                           input bit push, input exp_t e);
    bit ok = 1'b0;
    int waited = 0;
    in_valid = 1'b1; A = a; B = b; in_first = first; in_last = last;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
      waited++;
      if (!ok && waited > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    if (ok && push) sb.push_back(e);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    idle(2);
  endtask

  vec_t  vecs[9];
  exp_t  e, none;
  int    base;
  longint sum;

  initial begin
    vecs[0] = '{a: 24576,    b: 32768, y: 49152,    sat: 1'b0};
    vecs[1] = '{a: 1638400,  b: 32768, y: 2097151,  sat: 1'b1};
    vecs[2] = '{a: -1638400, b: 32768, y: -2097151, sat: 1'b1};
`ifdef REDONDEO_EN
    vecs[3] = '{a: 1,        b: 8192,  y: 1,        sat: 1'b0};
    vecs[4] = '{a: -1,       b: 8192,  y: 0,        sat: 1'b0};
`else
    vecs[3] = '{a: 1,        b: 8192,  y: 0,        sat: 1'b0};
    vecs[4] = '{a: -1,       b: 8192,  y: -1,       sat: 1'b0};
`endif
    vecs[5] = '{a: 0,        b: 12345, y: 0,        sat: 1'b0};
    vecs[6] = '{a: -2097152, b: 16384, y: -2097151, sat: 1'b1};
    vecs[7] = '{a: 2097151,  b: 16384, y: 2097151,  sat: 1'b0};
    vecs[8] = '{a: -16384,   b: 16384, y: -16384,   sat: 1'b0};
    none = '0;

    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    A = '0; B = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_Y", Y, 0);
    check("reset_sat_flag", sat_flag, 0);
    reset = 1'b0;
    idle(1);

    // Latency of a single-beat frame: output exactly three cycles after acceptance.
    e = '{y: 49152, sat: 1'b0};
    send_beat(24576, 32768, 1'b1, 1'b1, 1'b1, e);
    check("lat_t+1", out_valid, 0);
    idle(1);
    check("lat_t+2", out_valid, 0);
    idle(1);
    check("lat_t+3", out_valid, 1);
    drain();

    // Table of single-beat frames, back to back.
    for (int i = 0; i < 9; i++) begin
      e.y = vecs[i].y; e.sat = vecs[i].sat;
      send_beat(vecs[i].a, vecs[i].b, 1'b1, 1'b1, 1'b1, e);
    end
    drain();

    // Four-beat frame with a gap: 4 x 0.5 = 2.0, one result only.
    base = n_out;
    send_beat(16384, 8192, 1'b1, 1'b0, 1'b0, none);
    send_beat(16384, 8192, 1'b0, 1'b0, 1'b0, none);
    idle(1);
    send_beat(16384, 8192, 1'b0, 1'b0, 1'b0, none);
    e = '{y: 32768, sat: 1'b0};
    send_beat(16384, 8192, 1'b0, 1'b1, 1'b1, e);
    drain();
    check("frame_pulses", n_out - base, 1);

    // Missing first tag after a completed frame still starts from zero.
    e = '{y: 16384, sat: 1'b0};
    send_beat(16384, 16384, 1'b0, 1'b1, 1'b1, e);
    drain();

    // Backpressure: three results queued while the consumer stalls.
    base = n_out;
    out_ready = 1'b0;
    send_beat(16384, 16384, 1'b1, 1'b1, 1'b1, '{y: 16384,  sat: 1'b0});
    send_beat(32768, 16384, 1'b1, 1'b1, 1'b1, '{y: 32768,  sat: 1'b0});
    send_beat(-16384, 16384, 1'b1, 1'b1, 1'b1, '{y: -16384, sat: 1'b0});
    idle(4);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_Y_first", Y, 16384);
    idle(3);
    check("stall_Y_stable", Y, 16384);
    check("stall_no_output", n_out - base, 0);
    out_ready = 1'b1;
    drain();
    check("stall_delivered", n_out - base, 3);

    // Reset in the middle of a frame discards the partial sum.
    send_beat(1638400, 16384, 1'b1, 1'b0, 1'b0, none);
    send_beat(1638400, 16384, 1'b0, 1'b0, 1'b0, none);
    reset = 1'b1;
    idle(1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_Y", Y, 0);
    idle(1);
    reset = 1'b0;
    send_beat(16384, 16384, 1'b0, 1'b1, 1'b1, '{y: 16384, sat: 1'b0});
    drain();

    // Random three-beat frames under random backpressure, checked against a model.
    bp_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      sum = 0;
      for (int k = 0; k < 3; k++) begin
        logic signed [W-1:0] ra, rb;
        ra = W'($urandom);
        rb = W'($urandom);
        sum += longint'(ra) * longint'(rb);
        e = model(sum);
        send_beat(ra, rb, k == 0, k == 2, k == 2, e);
      end
    end
    bp_en = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
